// File: rtl/seq_shift_unit_if.sv
// Handshake/result bundle between the control unit (master) and seq_shift_unit (slave).
// SEQ_SHIFT_ABORT_EN adds the abort request line.
interface seq_shift_unit_if #(
    parameter int WIDTH = 16
);
    localparam int AW = $clog2(WIDTH);

    logic             start;
    logic [WIDTH-1:0] operand;
    logic [AW-1:0]    amount;
    logic [1:0]       op;
`ifdef SEQ_SHIFT_ABORT_EN
    logic             abort;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;

    modport master (
        output start, operand, amount, op,
`ifdef SEQ_SHIFT_ABORT_EN
        output abort,
`endif
        input  busy, done, result, carry
    );

    modport slave (
        input  start, operand, amount, op,
`ifdef SEQ_SHIFT_ABORT_EN
        input  abort,
`endif
        output busy, done, result, carry
    );
endinterface

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate engine: SLL/SRL/SRA/ROR by 0..WIDTH-1, STEP bits per cycle.
// Optional SEQ_SHIFT_ABORT_EN adds an abort input that drops a running operation.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | waiting for start; result/carry hold last outcome
//  S_SHIFT | shifting up to STEP positions per cycle, counting down
//  S_DONE  | one-cycle done pulse; result/carry valid
module seq_shift_unit #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    seq_shift_unit_if.slave bus
);
    localparam int            AW     = $clog2(WIDTH);
    localparam logic [AW-1:0] STEP_W = AW'(STEP);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    remaining_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;

    logic             accept;
    logic             abort_hit;
    logic             last_step;
    logic [AW-1:0]    step_n;
    logic [WIDTH-1:0] shift_val;
    logic             shift_carry;

    // Abort only applies to an operation in flight; in IDLE a start always wins.
`ifdef SEQ_SHIFT_ABORT_EN
    assign abort_hit = bus.abort && (state_q != S_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign accept    = (state_q == S_IDLE) && bus.start;
    assign last_step = (remaining_q <= STEP_W);
    assign step_n    = last_step ? remaining_q : STEP_W;

    // Unrolled chain of single-bit steps; only the first step_n stages are active.
    always_comb begin
        shift_val   = result_q;
        shift_carry = carry_q;
        for (int i = 0; i < STEP; i++) begin
            if (AW'(i) < step_n) begin
                case (op_q)
                    OP_SLL: begin
                        shift_carry = shift_val[WIDTH-1];
                        shift_val   = {shift_val[WIDTH-2:0], 1'b0};
                    end
                    OP_SRL: begin
                        shift_carry = shift_val[0];
                        shift_val   = {1'b0, shift_val[WIDTH-1:1]};
                    end
                    OP_SRA: begin
                        shift_carry = shift_val[0];
                        shift_val   = {shift_val[WIDTH-1], shift_val[WIDTH-1:1]};
                    end
                    default: begin
                        shift_carry = shift_val[0];
                        shift_val   = {shift_val[0], shift_val[WIDTH-1:1]};
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = (bus.amount == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                bus.busy = 1'b1;
                if (abort_hit) begin
                    state_d = S_IDLE;
                end else if (last_step) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bus.busy = 1'b1;
                bus.done = !abort_hit;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // result doubles as the working register so it holds after done until the next accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining_q <= '0;
            op_q        <= OP_SLL;
            result_q    <= '0;
            carry_q     <= 1'b0;
        end else if (accept) begin
            remaining_q <= bus.amount;
            op_q        <= bus.op;
            result_q    <= bus.operand;
            carry_q     <= 1'b0;
        end else if ((state_q == S_SHIFT) && !abort_hit) begin
            remaining_q <= remaining_q - step_n;
            result_q    <= shift_val;
            carry_q     <= shift_carry;
        end
    end

    assign bus.result = result_q;
    assign bus.carry  = carry_q;
endmodule
